// File: rtl/ascon_hash_stream_wrapper_pkg.sv
// ascon_hash_stream_wrapper_pkg: wrapper FSM states, Ascon constants and the permutation round
package ascon_hash_stream_wrapper_pkg;
  typedef enum logic [1:0] {IDLE, LOADED, HASH, OUT} state_e;
  typedef logic [4:0][63:0] state_t;
  localparam logic [63:0] IV = 64'h00400c0000000100;
  function automatic bit legal_w(input int w);
    return w == 1 || w == 2 || w == 4 || w == 8 || w == 16 || w == 32;
  endfunction
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction
  // Lane-parallel chi: t[k] = ~x[k] & x[k+1 mod 5], done on the whole packed state
  function automatic state_t ascon_round(input state_t s, input logic [3:0] i);
    state_t x, t;
    x = s;
    x[2] ^= {56'b0, 4'hf - i, i};
    x[0] ^= x[4];
    x[4] ^= x[3];
    x[2] ^= x[1];
    t = ~x & {x[0], x[4:1]};
    x ^= {t[0], t[4:1]};
    x[1] ^= x[0];
    x[0] ^= x[4];
    x[3] ^= x[2];
    x[2] = ~x[2];
    x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
    x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
    x[2] ^= ror(x[2], 1) ^ ror(x[2], 6);
    x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
    x[4] ^= ror(x[4], 7) ^ ror(x[4], 41);
    return x;
  endfunction
endpackage

// File: rtl/ascon_hash_core.sv
// ascon_hash_core: iterative Ascon-Hash over a single-block message, one round per clock
module ascon_hash_core import ascon_hash_stream_wrapper_pkg::*; #(
  parameter int A = 12,
  parameter int B = 12,
  parameter int L = 256,
  parameter int Y = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [Y-1:0] msg,
  output logic         hash_ready,
  output logic [L-1:0] digest
);
  state_t s, r;
  logic run, seg_end;
  logic [3:0] rnd, seg, lim;
  // seg 0: init perm, seg 1: absorb perm, seg 2..: squeeze perms; each seg end after 0 yields 64 digest bits
  always_comb begin
    lim = seg < 4'd2 ? 4'(A) : 4'(B);
    seg_end = rnd == lim - 4'd1;
    r = ascon_round(s, 4'd12 - lim + rnd);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s <= '0;
      run <= 1'b0;
      rnd <= '0;
      seg <= '0;
      hash_ready <= 1'b0;
      digest <= '0;
    end else if (start && !run && !hash_ready) begin
      s <= {256'b0, IV};
      run <= 1'b1;
    end else if (run) begin
      s <= {r[4:1], r[0] ^ (seg_end && seg == '0 ? 64'({msg, 1'b1}) << (63 - Y) : 64'b0)};
      rnd <= seg_end ? '0 : rnd + 4'd1;
      seg <= seg + 4'(seg_end);
      if (seg_end && seg != '0) digest <= {digest[L-65:0], r[0]};
      if (seg_end && seg == 4'(L / 64)) begin
        run <= 1'b0;
        hash_ready <= 1'b1;
      end
    end
endmodule

// File: rtl/ascon_hash_stream_wrapper_piso.sv
// ascon_hash_stream_wrapper_piso: parallel-load digest shifter with a W-bit valid/ready output
module ascon_hash_stream_wrapper_piso #(
  parameter int L = 256,
  parameter int W = 1,
  parameter bit LSB1ST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [L-1:0] din,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready,
  output logic         last
);
  localparam int CW = $clog2(L / W + 1);
  logic [L-1:0] sr;
  logic [CW-1:0] cnt;
  assign data = LSB1ST ? sr[W-1:0] : sr[L-1 -: W];
  assign last = valid && ready && cnt == CW'(L / W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sr <= din;
      cnt <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      sr <= LSB1ST ? sr >> W : sr << W;
      cnt <= last ? '0 : cnt + 1'b1;
      valid <= !last;
    end
endmodule

// File: rtl/ascon_hash_stream_wrapper.sv
// ascon_hash_stream_wrapper: W-bit valid/ready message in and digest out around one Ascon-Hash core
module ascon_hash_stream_wrapper import ascon_hash_stream_wrapper_pkg::*; #(
  parameter int R = 64,
  parameter int A = 12,
  parameter int B = 12,
  parameter int H = 256,
  parameter int L = 256,
  parameter int Y = 40,
  parameter int W = 1,
  parameter bit LSB1ST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  input  logic [W-1:0] msg_data,
  output logic         msg_ready,
  input  logic         start,
  output logic         start_err,
  output logic         busy,
  output logic         dig_valid,
  output logic [W-1:0] dig_data,
  input  logic         dig_ready,
  output logic         done
);
  localparam int CW = $clog2((Y > L ? Y : L) / W + 1);
  if (!legal_w(W) || Y % W != 0 || L % W != 0 || R != 64 || H != L || Y >= R || L % R != 0 || L <= R) begin : g_bad_params
    $error("ascon_hash_stream_wrapper: illegal parameter set");
  end
  state_e state, nxt;
  logic [Y-1:0] msg;
  logic [CW-1:0] beat_cnt;
  logic [L-1:0] digest;
  logic clr_q, core_rst_n, hash_ready, accept, last_beat, last_dig;
  assign msg_ready = state == IDLE && !rst;
  assign accept = msg_valid && msg_ready;
  assign last_beat = accept && beat_cnt == CW'(Y / W - 1);
  assign busy = state == HASH || state == OUT;
  assign done = clr_q;
  assign core_rst_n = ~(rst | clr_q);
  always_comb
    nxt = last_beat ? LOADED
        : state == LOADED && start ? HASH
        : state == HASH && hash_ready ? OUT
        : state == OUT && last_dig ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      msg <= '0;
      beat_cnt <= '0;
      clr_q <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state <= nxt;
      clr_q <= state == OUT && last_dig;
      start_err <= start && state != LOADED;
      if (accept) begin
        msg <= Y'({msg, msg_data});
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  ascon_hash_core #(.A(A), .B(B), .L(L), .Y(Y)) u_core (
    .clk(clk),
    .rst_n(core_rst_n),
    .start(state == LOADED && start),
    .msg(msg),
    .hash_ready(hash_ready),
    .digest(digest)
  );
  ascon_hash_stream_wrapper_piso #(.L(L), .W(W), .LSB1ST(LSB1ST)) u_piso (
    .clk(clk),
    .rst(rst),
    .load(state == HASH && hash_ready),
    .din(digest),
    .valid(dig_valid),
    .data(dig_data),
    .ready(dig_ready),
    .last(last_dig)
  );
endmodule

// File: tb/tb_ascon_hash_stream_wrapper.sv
// tb_ascon_hash_stream_wrapper: scoreboard bench, W=8 MSB-first digest against a software Ascon-Hash model
module tb_ascon_hash_stream_wrapper;
  localparam int W = 8;
  typedef logic [4:0][63:0] st_t;
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
  logic clk = 0, rst = 1, msg_valid = 0, start = 0, dig_ready = 0;
  logic [W-1:0] msg_data = '0;
  logic msg_ready, start_err, busy, dig_valid, done;
  logic [W-1:0] dig_data;
  int total = 0, bad = 0, done_cnt = 0, rdy_mode = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] prev_data = '0;
  logic prev_stall = 0, prev_done = 0;
  logic [39:0] m;
  int c;

  always #5 clk = ~clk;

  ascon_hash_stream_wrapper #(.W(W), .LSB1ST(1'b0)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .start(start), .start_err(start_err), .busy(busy), .dig_valid(dig_valid),
    .dig_data(dig_data), .dig_ready(dig_ready), .done(done)
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] t;
    t = {v, v} >> n;
    return t[63:0];
  endfunction

  function automatic st_t perm(input st_t s, input int n);
    logic [4:0] v;
    for (int r = 12 - n; r < 12; r++) begin
      s[2] ^= 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]} = v;
      end
      for (int k = 0; k < 5; k++) s[k] ^= rotr(s[k], ROT[k][0]) ^ rotr(s[k], ROT[k][1]);
    end
    return s;
  endfunction

  function automatic logic [255:0] ref_hash(input logic [39:0] msg);
    st_t s;
    logic [255:0] h;
    s = '0;
    h = '0;
    s[0] = 64'h00400c0000000100;
    s = perm(s, 12);
    s[0] ^= {msg, 1'b1, 23'b0};
    s = perm(s, 12);
    for (int i = 0; i < 4; i++) begin
      h = {h[191:0], s[0]};
      if (i < 3) s = perm(s, 12);
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [39:0] msg, input int from, input int to);
    for (int i = from; i < to; i++) begin
      msg_valid = 1;
      msg_data = msg[39 - 8 * i -: 8];
      tick();
    end
    msg_valid = 0;
  endtask

  task automatic push_exp(input logic [39:0] msg);
    logic [255:0] d;
    d = ref_hash(msg);
    for (int i = 0; i < 32; i++) exp_q.push_back(d[255 - 8 * i -: 8]);
  endtask

  task automatic wait_done(input string name);
    int n0, k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < 3000) begin
      tick();
      k++;
    end
    chk({name, "_done"}, 64'(done_cnt - n0), 1);
    chk({name, "_idle"}, {busy, msg_ready}, 2'b01);
    tick(3);
    chk({name, "_done_once"}, 64'(done_cnt - n0), 1);
  endtask

  task automatic finish_hash(input string name, input logic [39:0] msg);
    push_exp(msg);
    start = 1;
    tick();
    start = 0;
    chk({name, "_busy"}, {busy, start_err}, 2'b10);
    wait_done(name);
  endtask

  task automatic run_hash(input string name, input logic [39:0] msg, input int mode);
    rdy_mode = mode;
    load(msg, 0, 5);
    chk({name, "_loaded"}, {msg_ready, busy}, 2'b00);
    finish_hash(name, msg);
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    #1;
    chk("rst_outputs", {msg_ready, start_err, busy, dig_valid, dig_data, done}, 0);
    tick(2);
    #2 rst = 0;
    tick();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    dig_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_done = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {dig_valid, dig_data}, {1'b1, prev_data});
      if (dig_valid && dig_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("dig_beat", dig_data, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("done_single", prev_done, 0);
        chk("done_drained", exp_q.size(), 0);
      end
      prev_done = done;
      prev_stall = dig_valid && !dig_ready;
      prev_data = dig_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_outputs", {msg_ready, start_err, busy, dig_valid, dig_data, done}, 0);
    #2 rst = 0;
    tick();
    chk("ready_after_reset", msg_ready, 1);
    run_hash("fixed", 40'h0123456789, 0);
    m = {8'($urandom), $urandom};
    run_hash("rand_stall", m, 1);
    // start while still loading is rejected without disturbing the load
    m = {8'($urandom), $urandom};
    load(m, 0, 2);
    start = 1;
    tick();
    start = 0;
    chk("idle_start_err", {start_err, busy}, 2'b10);
    tick();
    chk("start_err_pulse", start_err, 0);
    load(m, 2, 5);
    finish_hash("after_early_start", m);
    // start coinciding with the last beat, then stray beats while LOADED
    m = {8'($urandom), $urandom};
    load(m, 0, 4);
    msg_valid = 1;
    msg_data = m[7:0];
    start = 1;
    tick();
    msg_valid = 0;
    start = 0;
    chk("last_beat_start_err", {start_err, msg_ready, busy}, 3'b100);
    msg_valid = 1;
    msg_data = 8'ha5;
    tick(3);
    msg_valid = 0;
    chk("start_not_queued", busy, 0);
    push_exp(m);
    start = 1;
    tick();
    start = 0;
    tick(5);
    start = 1;
    tick();
    start = 0;
    chk("hash_start_err", {start_err, busy}, 2'b11);
    wait_done("stray_beats");
    run_hash("b2b_a", 40'h0123456789, 1);
    run_hash("b2b_b", 40'hffffffffff, 1);
    // reset in HASH, in OUT and after a partial load
    m = {8'($urandom), $urandom};
    load(m, 0, 5);
    start = 1;
    tick();
    start = 0;
    tick(10);
    pulse_rst();
    rdy_mode = 2;
    load(m, 0, 5);
    start = 1;
    tick();
    start = 0;
    c = 0;
    while (!dig_valid && c < 500) begin
      tick();
      c++;
    end
    chk("out_reached", dig_valid, 1);
    tick(3);
    pulse_rst();
    rdy_mode = 1;
    load(40'h1122334455, 0, 2);
    pulse_rst();
    chk("ready_after_partial", msg_ready, 1);
    m = {8'($urandom), $urandom};
    run_hash("fresh_after_reset", m, 1);
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
